// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard unit between DC and EX that stalls issue while a used source has in-flight writes.
// Define HAZARD_SCOREBOARD_FWD_EN to enable writeback bypass of the register that retires this cycle.
module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_IDX_W    = 5,
  parameter int NUM_SRC      = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic                         issue_writes,
  input  logic [REG_IDX_W-1:0]         issue_rd,
  input  logic [NUM_SRC*REG_IDX_W-1:0] src_idx,
  input  logic [NUM_SRC-1:0]           src_used,
  input  logic                         wb_valid,
  input  logic [REG_IDX_W-1:0]         wb_rd,
  input  logic [WIDTH-1:0]             wb_data,
  input  logic                         cancel_valid,
  input  logic [REG_IDX_W-1:0]         cancel_rd,
  output logic                         stall,
  output logic [NUM_REGS-1:0]          pending,
  output logic                         err,
  output logic [NUM_SRC-1:0]           fwd_sel,
  output logic [NUM_SRC*WIDTH-1:0]     fwd_data
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  logic [CNT_W-1:0] cnt    [NUM_REGS];
  logic [CNT_W-1:0] cnt_nx [NUM_REGS];
  logic [NUM_REGS-1:0] uflow;
  logic [NUM_SRC-1:0] hz;
  logic str_hz, accept;
  assign str_hz = issue_writes && issue_rd != '0 && cnt[issue_rd] == CNT_W'(MAX_INFLIGHT);
  assign stall  = issue_valid && (|hz || str_hz);
  assign accept = issue_valid && !stall;
  // A full register stalls issue, so the sum never exceeds MAX_INFLIGHT and the top bit is a pure sign.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic inc, dwb, dcn;
    logic [CNT_W:0] sum;
    assign inc = (r != 0) && accept && issue_writes && issue_rd == REG_IDX_W'(r);
    assign dwb = (r != 0) && wb_valid && wb_rd == REG_IDX_W'(r);
    assign dcn = (r != 0) && cancel_valid && cancel_rd == REG_IDX_W'(r);
    assign sum = {1'b0, cnt[r]} + (CNT_W+1)'(inc) - (CNT_W+1)'(dwb) - (CNT_W+1)'(dcn);
    assign uflow[r] = sum[CNT_W];
    assign cnt_nx[r] = uflow[r] ? '0 : sum[CNT_W-1:0];
    assign pending[r] = cnt[r] != '0;
  end
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_IDX_W-1:0] s;
    logic live;
    assign s = src_idx[k*REG_IDX_W +: REG_IDX_W];
    assign live = src_used[k] && s != '0 && cnt[s] != '0;
`ifdef HAZARD_SCOREBOARD_FWD_EN
    // Bypass only when this writeback retires the last in-flight write (a same-edge cancel may retire the other).
    logic byp;
    assign byp = wb_valid && wb_rd == s &&
                 {1'b0, cnt[s]} == (CNT_W+1)'(1) + (CNT_W+1)'(cancel_valid && cancel_rd == s);
    assign hz[k] = live && !byp;
    assign fwd_sel[k] = live && byp;
    assign fwd_data[k*WIDTH +: WIDTH] = (live && byp) ? wb_data : '0;
`else
    assign hz[k] = live;
    assign fwd_sel[k] = 1'b0;
    assign fwd_data[k*WIDTH +: WIDTH] = '0;
`endif
  end
`ifndef HAZARD_SCOREBOARD_FWD_EN
  logic unused_wb;
  assign unused_wb = ^wb_data;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '{default: '0};
      err <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      err <= err || |uflow;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scoreboard bench with directed scenarios and random traffic against a counting reference model.
module tb_hazard_scoreboard;
  localparam int NR = 32;
  localparam int MI = 3;
  logic clk = 0, rst = 0;
  logic issue_valid, issue_writes, wb_valid, cancel_valid;
  logic [4:0] issue_rd, wb_rd, cancel_rd;
  logic [9:0] src_idx;
  logic [1:0] src_used;
  logic [31:0] wb_data;
  logic stall, err;
  logic [31:0] pending;
  logic [1:0] fwd_sel;
  logic [63:0] fwd_data;
  typedef struct {
    logic stall;
    logic [31:0] pend;
    logic err;
    logic [1:0] fsel;
    logic [63:0] fdat;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int cnt[NR];
  bit merr;
  int pool[5] = '{0, 4, 5, 7, 9};
`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam bit FWD = 1;
`else
  localparam bit FWD = 0;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_writes(issue_writes),
    .issue_rd(issue_rd), .src_idx(src_idx), .src_used(src_used), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .cancel_valid(cancel_valid), .cancel_rd(cancel_rd),
    .stall(stall), .pending(pending), .err(err), .fwd_sel(fwd_sel), .fwd_data(fwd_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current model state and the inputs now on the pins.
  function automatic exp_t predict();
    exp_t e;
    bit haz = 0;
    e.fsel = '0;
    e.fdat = '0;
    for (int k = 0; k < 2; k++) begin
      int idx = int'(src_idx[k*5 +: 5]);
      if (src_used[k] && idx != 0 && cnt[idx] > 0) begin
        int after = cnt[idx] - ((wb_valid && wb_rd == idx) ? 1 : 0) - ((cancel_valid && cancel_rd == idx) ? 1 : 0);
        if (FWD && wb_valid && wb_rd == idx && after == 0) begin
          e.fsel[k] = 1'b1;
          e.fdat[k*32 +: 32] = wb_data;
        end else haz = 1;
      end
    end
    e.stall = issue_valid && (haz || (issue_writes && issue_rd != 0 && cnt[issue_rd] == MI));
    for (int r = 0; r < NR; r++) e.pend[r] = cnt[r] > 0;
    e.err = merr;
    return e;
  endfunction

  task automatic model_edge(input bit st);
    for (int r = 1; r < NR; r++) begin
      int n = cnt[r];
      if (issue_valid && !st && issue_writes && issue_rd == r) n++;
      if (wb_valid && wb_rd == r) n--;
      if (cancel_valid && cancel_rd == r) n--;
      if (n < 0) begin
        n = 0;
        merr = 1;
      end
      cnt[r] = n;
    end
  endtask

  task automatic model_reset();
    foreach (cnt[r]) cnt[r] = 0;
    merr = 0;
  endtask

  task automatic step(input bit iv, iw, input int rd, s0, s1, input bit [1:0] used,
                      input bit wv, input int wr, input bit cv, input int cr, input int es);
    exp_t e;
    issue_valid = iv; issue_writes = iw; issue_rd = 5'(rd);
    src_idx = {5'(s1), 5'(s0)}; src_used = used;
    wb_valid = wv; wb_rd = 5'(wr); wb_data = $urandom;
    cancel_valid = cv; cancel_rd = 5'(cr);
    e = predict();
    q.push_back(e);
    if (es >= 0) begin
      #1;
      chk("directed_stall", 64'(stall), 64'(es));
    end
    @(posedge clk);
    model_edge(e.stall);
    #1;
  endtask

  function automatic int pick_busy();
    int c[$];
    for (int r = 1; r < NR; r++) if (cnt[r] > 0) c.push_back(r);
    if (c.size() > 0 && $urandom_range(0, 9) != 0) return c[$urandom_range(0, c.size() - 1)];
    return pool[$urandom_range(0, 4)];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", 64'(stall), 64'(e.stall));
      chk("pending", 64'(pending), 64'(e.pend));
      chk("err", 64'(err), 64'(e.err));
      chk("fwd_sel", 64'(fwd_sel), 64'(e.fsel));
      chk("fwd_data", fwd_data, e.fdat);
    end
  end

  initial begin
    {issue_valid, issue_writes, wb_valid, cancel_valid} = '0;
    {issue_rd, wb_rd, cancel_rd, src_idx, src_used, wb_data} = '0;
    model_reset();
    #1 rst = 1;
    #2;
    chk("reset_pending", 64'(pending), 0);
    chk("reset_err", 64'(err), 0);
    chk("reset_stall", 64'(stall), 0);
    chk("reset_fwd_sel", 64'(fwd_sel), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 0;
    // RAW stall through writeback
    step(1, 1, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0, 5, 0, 2'b01, 0, 0, 0, 0, 1);
    step(1, 0, 0, 5, 0, 2'b01, 1, 5, 0, 0, FWD ? 0 : 1);
    step(1, 0, 0, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    // structural limit on rd=7
    repeat (3) step(1, 1, 7, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 2'b00, 0, 0, 0, 0, 1);
    step(1, 1, 7, 0, 0, 2'b00, 1, 7, 0, 0, 1);
    step(1, 1, 7, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    chk("t3_pend7", 64'(pending[7]), 1);
    repeat (3) step(0, 0, 0, 0, 0, 2'b00, 1, 7, 0, 0, 0);
    // double decrement on one register
    repeat (2) step(1, 1, 9, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 2'b00, 1, 9, 1, 9, -1);
    chk("t4_pend9", 64'(pending[9]), 0);
    chk("t4_err", 64'(err), 0);
    // issue and writeback of the same register cancel out
    step(1, 1, 4, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 2'b00, 1, 4, 0, 0, 0);
    chk("t6_pend4", 64'(pending[4]), 1);
    chk("t6_err", 64'(err), 0);
    step(0, 0, 0, 0, 0, 2'b00, 1, 4, 0, 0, -1);
    // r0 and unused ports never stall; rd=0 is not tracked
    step(1, 1, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 2'b01, 0, 0, 0, 0, 0);
    step(1, 1, 0, 7, 5, 2'b01, 0, 0, 0, 0, 0);
    chk("t5_pending", 64'(pending), 64'h20);
    step(1, 1, 5, 5, 0, 2'b01, 0, 0, 0, 0, 1);
    step(1, 1, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    // asynchronous reset mid-run with count[5]=2
    issue_valid = 1; issue_writes = 0; src_idx = 10'd5; src_used = 2'b01; wb_valid = 0; cancel_valid = 0;
    #1 chk("t1_pre_stall", 64'(stall), 1);
    #1 rst = 1;
    #1;
    chk("t1_pending", 64'(pending), 0);
    chk("t1_stall", 64'(stall), 0);
    model_reset();
    @(posedge clk);
    #3 rst = 0;
    step(0, 0, 0, 0, 0, 2'b00, 1, 5, 0, 0, -1);
    chk("t1_err", 64'(err), 1);
    #1 rst = 1;
    model_reset();
    @(posedge clk);
    #3 rst = 0;
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1), pool[$urandom_range(0, 4)],
           pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)], 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 4, pick_busy(), $urandom_range(0, 9) == 0, pick_busy(), -1);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
